pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter BTB_ENTRIES, default 8, branch-target-buffer entries; power of two, minimum 2.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold current PC (decode/hazard stall).
REQ-007 redirect_valid  in  1  execute-stage resolved redirect (mispredict, jal, jalr).
REQ-008 redirect_target  in  WIDTH  redirect destination.
REQ-009 btb_upd_valid  in  1  write one BTB entry.
REQ-010 btb_upd_pc  in  WIDTH  PC of the taken control-flow instruction.
REQ-011 btb_upd_target  in  WIDTH  its target.
REQ-012 PC  out  WIDTH  current fetch address.
REQ-013 PC_plus_4  out  WIDTH  PC + 4, for the result mux.
REQ-014 pc_valid  out  1  PC is a legal fetch this cycle.
REQ-015 pred_taken  out  1  BTB hit on current PC.
REQ-016 trap_misaligned  out  1  unit is in TRAP state.

Function
REQ-017 States: BOOT, RUN, TRAP; encoding is an enum.
REQ-018 BOOT: PC = RESET_VECTOR, pc_valid = 0, pred_taken = 0; unconditionally goes to RUN after one clock; stall and redirect are ignored.
REQ-019 RUN, next-PC priority: redirect_valid > stall > BTB hit > PC + 4.
REQ-020 RUN: redirect_valid with redirect_target[1:0] == 0 loads redirect_target into PC next cycle; stays in RUN.
REQ-021 RUN: redirect_valid with redirect_target[1:0] != 0 goes to TRAP; PC keeps its old value.
REQ-022 RUN: stall without redirect holds PC, holds pc_valid = 1, and holds pred_taken consistent with the held PC.
REQ-023 RUN: a BTB hit loads the stored target next cycle; otherwise PC + 4 is loaded, wrapping modulo 2^WIDTH with no flag.
REQ-024 TRAP: pc_valid = 0, pred_taken = 0, trap_misaligned = 1; stall is ignored; PC is held.
REQ-025 TRAP: a redirect to an aligned target loads that target and returns to RUN; a misaligned redirect stays in TRAP.
REQ-026 pc_valid = 1 only in RUN; trap_misaligned = 1 only in TRAP.
REQ-027 PC_plus_4 = PC + 4 combinationally in every state.
REQ-028 BTB is direct-mapped.
- IDX = log2(BTB_ENTRIES).
- Index = PC[IDX+1:2].
- Tag = PC[WIDTH-1:IDX+2].
- Each entry holds a valid bit, tag and target.
REQ-029 Lookup is combinational on PC. A hit requires the indexed entry to be valid with a matching tag; a hit whose target[1:0] != 0 is treated as a miss.
REQ-030 Update writes on the rising edge and sets valid; the written entry is visible from the next cycle only, and a same-cycle lookup sees the old contents.
REQ-031 An update is accepted in every state, including BOOT, TRAP and stall cycles.

Reset
REQ-032 While rst = 0: state = BOOT, PC = RESET_VECTOR, all BTB valid bits = 0, pc_valid = 0, pred_taken = 0, trap_misaligned = 0.
REQ-033 Reset assertion mid-operation takes effect immediately (asynchronous).
REQ-034 On release, the first clock edge enters RUN; the tag and target arrays need no reset.

Structure
REQ-035 The shared package holds the state enum (BOOT, RUN, TRAP) and the constant INSTR_BYTES = 4.
REQ-036 The BTB is one sub-module, pc_btb (parameters WIDTH and BTB_ENTRIES), containing the lookup and update logic.
REQ-037 The state register and PC register live in pc_fetch_unit.

Verification
REQ-038 Reset release, no inputs -> PC sequence 0 (pc_valid = 0), 0, 4, 8, 12 (pc_valid = 1).
REQ-039 Update pc = 0x10, target = 0x40, then free run -> PC sequence 0x0C, 0x10 (pred_taken = 1), 0x40.
REQ-040 stall = 1 and redirect to 0x80 in the same RUN cycle -> PC = 0x80 next cycle.
REQ-041 Redirect to 0x102 -> TRAP, pc_valid = 0, PC held; redirect to 0x200 -> RUN with PC = 0x200.
REQ-042 rst driven low mid-run, asynchronously to clk -> PC = RESET_VECTOR and all BTB valid bits cleared immediately; a former hit address now yields PC + 4.
REQ-043 PC = 0xFFFF_FFFC, no redirect -> next PC = 0x0000_0000, no trap.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit and its branch target buffer.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    TRAP = 2'b10
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Instruction addresses must be word aligned; a non-zero low pair is illegal.
  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single-entry write per clock.
module pc_btb
  import pc_fetch_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BTB_ENTRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] lookup_pc_i,
  output logic             hit_o,
  output logic [WIDTH-1:0] target_o,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic [WIDTH-1:0] upd_target_i
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_q [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx_s;
  logic [IDX-1:0]   wr_idx_s;
  logic [TAG_W-1:0] rd_tag_s;

  assign rd_idx_s = lookup_pc_i[IDX+1:2];
  assign rd_tag_s = lookup_pc_i[WIDTH-1:IDX+2];
  assign wr_idx_s = upd_pc_i[IDX+1:2];

  // A stored target that is not word aligned can never be fetched, so it reads as a miss.
  assign hit_o    = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s)
                    && is_aligned(target_q[rd_idx_s][1:0]);
  assign target_o = target_q[rd_idx_s];

  // Valid bits: cleared by reset, set by an update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      valid_q[wr_idx_s] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and target storage carries no reset; the valid bit guards stale contents.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i) begin
      tag_q[wr_idx_s]    <= upd_pc_i[WIDTH-1:IDX+2];
      target_q[wr_idx_s] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-address generator: BOOT/RUN/TRAP sequencing, redirect/stall/BTB next-PC selection.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int               BTB_ENTRIES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             btb_upd_valid,
  input  logic [WIDTH-1:0] btb_upd_pc,
  input  logic [WIDTH-1:0] btb_upd_target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus_4,
  output logic             pc_valid,
  output logic             pred_taken,
  output logic             trap_misaligned
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4_s;
  logic             btb_hit_s;
  logic [WIDTH-1:0] btb_target_s;
  logic             redir_ok_s;

  pc_btb #(
    .WIDTH       (WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i        (clk),
    .rst_ni       (rst),
    .lookup_pc_i  (pc_q),
    .hit_o        (btb_hit_s),
    .target_o     (btb_target_s),
    .upd_valid_i  (btb_upd_valid),
    .upd_pc_i     (btb_upd_pc),
    .upd_target_i (btb_upd_target)
  );

  assign pc_plus4_s = pc_q + WIDTH'(INSTR_BYTES);
  assign redir_ok_s = is_aligned(redirect_target[1:0]);

  // Next-state and next-PC selection; a misaligned redirect never changes the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          if (redir_ok_s) begin
            pc_d = redirect_target;
          end else begin
            state_d = TRAP;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (btb_hit_s) begin
          pc_d = btb_target_s;
        end else begin
          pc_d = pc_plus4_s;
        end
      end
      TRAP: begin
        if (redirect_valid && redir_ok_s) begin
          pc_d    = redirect_target;
          state_d = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC              = pc_q;
  assign PC_plus_4       = pc_plus4_s;
  assign pc_valid        = (state_q == RUN);
  assign pred_taken      = (state_q == RUN) && btb_hit_s;
  assign trap_misaligned = (state_q == TRAP);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit with a queue-based scoreboard of per-cycle expectations.
module tb_pc_fetch_unit;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] ut;
    logic [31:0] pc;
    logic        v;
    logic        p;
    logic        t;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        pc_valid;
  logic        pred_taken;
  logic        trap_misaligned;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  vec_t sb[$];
  vec_t tbl[21];

  pc_fetch_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .BTB_ENTRIES  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .btb_upd_valid   (btb_upd_valid),
    .btb_upd_pc      (btb_upd_pc),
    .btb_upd_target  (btb_upd_target),
    .PC              (PC),
    .PC_plus_4       (PC_plus_4),
    .pc_valid        (pc_valid),
    .pred_taken      (pred_taken),
    .trap_misaligned (trap_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic rv, logic [31:0] rt, logic uv, logic [31:0] upc,
                              logic [31:0] ut, logic [31:0] pc, logic v, logic p, logic t);
    vec_t r;
    r.stall = s; r.rv = rv; r.rt = rt; r.uv = uv; r.upc = upc; r.ut = ut;
    r.pc = pc; r.v = v; r.p = p; r.t = t;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, advance to just after the next edge.
  task automatic step(input vec_t r);
    stall           = r.stall;
    redirect_valid  = r.rv;
    redirect_target = r.rt;
    btb_upd_valid   = r.uv;
    btb_upd_pc      = r.upc;
    btb_upd_target  = r.ut;
    sb.push_back(r);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      checks++;
      if ({PC, PC_plus_4, pc_valid, pred_taken, trap_misaligned} !==
          {e.pc, e.pc + 32'd4, e.v, e.p, e.t}) begin
        errors++;
        $display("FAIL cycle%0d: got pc=%h pc4=%h v=%b p=%b t=%b, want pc=%h pc4=%h v=%b p=%b t=%b",
                 cyc, PC, PC_plus_4, pc_valid, pred_taken, trap_misaligned,
                 e.pc, e.pc + 32'd4, e.v, e.p, e.t);
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    //           stall rv  rt            uv  upc           ut            pc            v     p     t
    tbl[0]  = mk(1'b1, 1'b1, 32'h80,  1'b1, 32'h10,  32'h40,  32'h0,   1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h4,   1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h8,   1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'hC,   1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h10,  1'b1, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h40,  1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h44,  1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 32'h80,  1'b0, 32'h0,   32'h0,   32'h44,  1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0,   32'h80,  1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h10,  1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h10,  1'b1, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   32'h0,   32'h40,  1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 32'h3,   1'b1, 32'h204, 32'h300, 32'h40,  1'b0, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,   32'h40,  1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h200, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 32'h502, 32'h204, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h300, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h304, 1'b1, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h308, 32'h400, 32'h308, 1'b1, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h30C, 1'b1, 1'b0, 1'b0);

    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    btb_upd_valid = 1'b0; btb_upd_pc = 32'h0; btb_upd_target = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check32("rst_pc",    PC,                      32'h0);
    check32("rst_pc4",   PC_plus_4,               32'h4);
    check32("rst_valid", {31'd0, pc_valid},        32'd0);
    check32("rst_pred",  {31'd0, pred_taken},      32'd0);
    check32("rst_trap",  {31'd0, trap_misaligned}, 32'd0);

    rst = 1'b1;
    for (int i = 0; i < 21; i++) step(tbl[i]);

    // Asynchronous reset mid-run, asserted well away from any clock edge.
    #2 rst = 1'b0;
    #1;
    check32("async_pc",    PC,                      32'h0);
    check32("async_valid", {31'd0, pc_valid},        32'd0);
    check32("async_pred",  {31'd0, pred_taken},      32'd0);
    check32("async_trap",  {31'd0, trap_misaligned}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Former BTB hit at 0x10 must now fall through to PC+4, then wrap past the top of memory.
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h4,         1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h8,         1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'hC,         1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h10,        1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h14,        1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 32'h0, 32'h4,         1'b1, 1'b0, 1'b0));

    check32("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
